// File: rtl/coeff_rate_accumulator_if.sv
// Coefficient handshake and sign-bit cost request/response bundle for the block rate accumulator.
interface coeff_rate_accumulator_if;
    logic        coef_valid;
    logic        coef_ready;
    logic [31:0] coef_ctx_cost;
    logic [15:0] coef_abs_level;
    logic        coef_last;
    logic        sign_start;
    logic        sign_done;
    logic [31:0] sign_bit_cost;

    // master: upstream cost stage plus sign-bit cost stage; slave: the accumulator
    modport master (
        output coef_valid, coef_ctx_cost, coef_abs_level, coef_last, sign_done, sign_bit_cost,
        input  coef_ready, sign_start
    );
    modport slave (
        input  coef_valid, coef_ctx_cost, coef_abs_level, coef_last, sign_done, sign_bit_cost,
        output coef_ready, sign_start
    );
endinterface

// File: rtl/coeff_rate_accumulator.sv
// Per-block CABAC rate accumulator: sums context bin costs plus one sign cost per nonzero
// coefficient into a saturating total, with a timeout fallback when the sign stage stalls.
module coeff_rate_accumulator #(
    parameter int unsigned IEP_RATE     = 32768,
    parameter int unsigned ACC_W        = 32,
    parameter int unsigned MAX_COEFFS   = 16,
    parameter int unsigned SIGN_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 blk_start,
    coeff_rate_accumulator_if.slave cif,
    output logic [ACC_W-1:0]     blk_rate,
    output logic                 blk_done,
    output logic [4:0]           nz_count,
    output logic                 sign_err
);
    localparam int unsigned CNT_W = $clog2(MAX_COEFFS + 1);
    localparam int unsigned TMO_W = $clog2(SIGN_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, WAIT_SIGN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               last_q, last_d;
    logic [ACC_W-1:0]   acc_d;
    logic [4:0]         nz_d;
    logic               err_d;
    logic               ready_d, start_d, done_d;
    logic               nz_c, last_c, tmo_hit_c, accept_c;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    assign accept_c  = (state_q == ACCUM) && cif.coef_valid;
    assign nz_c      = (cif.coef_abs_level != 16'd0);
    assign last_c    = cif.coef_last || (CNT_W'(cnt_q + 1'b1) == CNT_W'(MAX_COEFFS));
    // timeout counter holds cycles spent in WAIT_SIGN, including the current one
    assign tmo_hit_c = (tmo_q == TMO_W'(SIGN_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (blk_start) state_d = ACCUM;
            ACCUM:     if (cif.coef_valid) begin
                           if (nz_c)        state_d = WAIT_SIGN;
                           else if (last_c) state_d = DONE;
                       end
            WAIT_SIGN: if (cif.sign_done || tmo_hit_c) state_d = last_q ? DONE : ACCUM;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d   = blk_rate;
        nz_d    = nz_count;
        cnt_d   = cnt_q;
        err_d   = sign_err;
        last_d  = last_q;
        tmo_d   = tmo_q;
        ready_d = (state_d == ACCUM);
        done_d  = (state_d == DONE);
        start_d = accept_c && nz_c;
        case (state_q)
            IDLE: if (blk_start) begin
                acc_d  = '0;
                nz_d   = 5'd0;
                cnt_d  = '0;
                err_d  = 1'b0;
                last_d = 1'b0;
            end
            ACCUM: if (cif.coef_valid) begin
                acc_d = sat_add(blk_rate, ACC_W'(cif.coef_ctx_cost));
                cnt_d = CNT_W'(cnt_q + 1'b1);
                if (nz_c) begin
                    nz_d   = 5'(nz_count + 5'd1);
                    last_d = last_c;
                    tmo_d  = TMO_W'(1);
                end
            end
            WAIT_SIGN: begin
                tmo_d = TMO_W'(tmo_q + 1'b1);
                // a response coinciding with the timeout still counts as a real sign cost
                if (cif.sign_done) begin
                    acc_d = sat_add(blk_rate, ACC_W'(cif.sign_bit_cost));
                end else if (tmo_hit_c) begin
                    acc_d = sat_add(blk_rate, ACC_W'(IEP_RATE));
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_rate       <= '0;
            nz_count       <= 5'd0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            last_q         <= 1'b0;
            sign_err       <= 1'b0;
            cif.coef_ready <= 1'b0;
            cif.sign_start <= 1'b0;
            blk_done       <= 1'b0;
        end else begin
            blk_rate       <= acc_d;
            nz_count       <= nz_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            last_q         <= last_d;
            sign_err       <= err_d;
            cif.coef_ready <= ready_d;
            cif.sign_start <= start_d;
            blk_done       <= done_d;
        end
    end
endmodule
